// File: rtl/bram_stream_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and skid FIFO sizing.
package bram_stream_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry register FIFO that catches BRAM read returns so downstream stalls never drop a word.
module stream_skid_fifo
   import bram_stream_pkg::*;
#(
   parameter int WIDTH = 17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               pop,
   output logic [COUNT_W-1:0] count,
   output logic [WIDTH-1:0]   head
);

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = slot0;

   // slot0 is always the head; a pop shifts slot1 forward, a push fills the first free slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (count == COUNT_W'(0)) begin
                  slot0 <= push_data;
                  count <= COUNT_W'(1);
               end else if (count == COUNT_W'(1)) begin
                  slot1 <= push_data;
                  count <= COUNT_W'(2);
               end
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - COUNT_W'(1);
            end
            2'b11: begin
               if (count == COUNT_W'(1)) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Scans BRAM addresses 0..DEPTH-1 into a valid/ready stream with full backpressure.
// Define BRAM_STREAM_READER_CLEAR_EN to write CLEAR_VALUE back to each address as it is read.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter int               DEPTH       = 19200,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] addr_read,
   input  logic [WIDTH-1:0]         data_out,
   output logic                     write_enable,
   output logic [$clog2(DEPTH)-1:0] addr_write,
   output logic [WIDTH-1:0]         data_in,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_last
);

   localparam int            AW        = $clog2(DEPTH);
   localparam int            OCC_W     = COUNT_W + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t             state;
   state_t             state_next;
   logic [AW-1:0]      counter;
   logic               inflight;
   logic               inflight_last;
   logic               rd_issue;
   logic               issue_last;
   logic               pop;
   logic               fifo_empty;
   logic [COUNT_W-1:0] fifo_count;
   logic [WIDTH:0]     fifo_head;
   logic [OCC_W-1:0]   occupancy;

   assign fifo_empty = (fifo_count == '0);
   assign m_valid    = !fifo_empty;
   assign pop        = m_valid && m_ready;
   assign m_data     = fifo_head[WIDTH-1:0];
   assign m_last     = fifo_head[WIDTH] && m_valid;
   assign addr_read  = counter;

   // A word leaving this cycle frees its slot in time for a read issued now; this sustains 1 word/cycle
   assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight) - OCC_W'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (issue_last) state_next = DRAIN;
         DRAIN:   if (fifo_empty && !inflight) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      done       = (state == DRAIN) && fifo_empty && !inflight;
      rd_issue   = (state == RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
      issue_last = rd_issue && (counter == LAST_ADDR);
   end

   // Counter parks on DEPTH-1 after the final issue and rewinds when the frame completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter       <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_issue;
         inflight_last <= issue_last;
         if (done) begin
            counter <= '0;
         end else if (rd_issue && !issue_last) begin
            counter <= counter + AW'(1);
         end
      end
   end

   stream_skid_fifo #(
      .WIDTH (WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, data_out}),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head)
   );

`ifdef BRAM_STREAM_READER_CLEAR_EN
   // BRAM is read-before-write, so the same-cycle write still returns the old word
   assign write_enable = rd_issue;
   assign addr_write   = counter;
   assign data_in      = busy ? CLEAR_VALUE : '0;
`else
   logic unused_clear;
   assign unused_clear = ^CLEAR_VALUE;
   assign write_enable = 1'b0;
   assign addr_write   = '0;
   assign data_in      = '0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: DEPTH=8 and DEPTH=2 instances, each with a registered-read BRAM model.
module tb_bram_stream_reader;

   localparam logic [15:0] CLR = 16'hABCD;

   logic clk = 1'b0;
   logic rst;
   logic preload;
   always #5 clk = ~clk;

   logic        start, busy, done, m_valid, m_ready, m_last, write_enable;
   logic [2:0]  addr_read, addr_write;
   logic [15:0] data_out, data_in, m_data;
   logic [15:0] mem [0:7];

   logic        start2, busy2, done2, m_valid2, m_ready2, m_last2, write_enable2;
   logic [0:0]  addr_read2, addr_write2;
   logic [15:0] data_out2, data_in2, m_data2;
   logic [15:0] mem2 [0:1];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'(i);
      end else if (write_enable) begin
         mem[addr_write] <= data_in;
      end
      data_out <= mem[addr_read];
   end

   always @(posedge clk) begin
      if (preload) begin
         mem2[0] <= 16'd0;
         mem2[1] <= 16'd1;
      end else if (write_enable2) begin
         mem2[addr_write2] <= data_in2;
      end
      data_out2 <= mem2[addr_read2];
   end

   bram_stream_reader #(.WIDTH(16), .DEPTH(8), .CLEAR_VALUE(CLR)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .addr_read(addr_read), .data_out(data_out), .write_enable(write_enable),
      .addr_write(addr_write), .data_in(data_in), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   bram_stream_reader #(.WIDTH(16), .DEPTH(2), .CLEAR_VALUE(CLR)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .addr_read(addr_read2), .data_out(data_out2), .write_enable(write_enable2),
      .addr_write(addr_write2), .data_in(data_in2), .m_valid(m_valid2),
      .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] got_data [16];
   logic        got_last [16];
   int          got_cycle [16];
   int          n_got, first_valid, done_cycle, n_done, busy_drop, stable_err;
   int          we_count;
   logic [15:0] we_mask;
   logic [2:0]  stall_addr;
   logic        end_busy;

   task automatic reset_dut();
      rst = 1'b1; preload = 1'b1;
      start = 1'b0; m_ready = 1'b0; start2 = 1'b0; m_ready2 = 1'b0;
      repeat (2) @(negedge clk);
      preload = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_preload();
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   // mode 0: ready always; mode 1: ready on k%3==0; mode 2: ready from cycle 14
   task automatic run_frame(input int mode, input int restart_k);
      logic        prev_hold;
      logic [15:0] prev_data;
      n_got = 0; first_valid = -1; done_cycle = -1; n_done = 0; busy_drop = 0;
      stable_err = 0; we_count = 0; we_mask = '0; stall_addr = '0; end_busy = 1'b1;
      prev_hold = 1'b0; prev_data = '0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         start   = (k == 0) || (k == restart_k);
         m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : (k >= 14);
         #1;
         if (prev_hold && m_valid && m_data !== prev_data) stable_err++;
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         if (m_valid && first_valid < 0) first_valid = k;
         if (m_valid && m_ready && n_got < 16) begin
            got_data[n_got] = m_data; got_last[n_got] = m_last; got_cycle[n_got] = k;
            n_got++;
         end
         if (write_enable) begin
            we_count++;
            if (k < 16) we_mask[k] = 1'b1;
         end
         if (k == 13) stall_addr = addr_read;
         if (k >= 1 && done_cycle < 0 && !busy) busy_drop++;
         if (done) begin
            n_done++;
            if (done_cycle < 0) done_cycle = k;
         end
         if (done_cycle >= 0 && k == done_cycle + 1) begin
            end_busy = busy;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      n_checks++;
      if ({m_valid, busy, done, m_last, write_enable, addr_read, addr_write, m_data, data_in} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {m_valid, busy, done, m_last, write_enable, addr_read, addr_write, m_data, data_in});
      end
      n_checks++;
      if ({m_valid2, busy2, done2, m_last2, addr_read2, m_data2} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs_d2: got %h expected 0",
                  {m_valid2, busy2, done2, m_last2, addr_read2, m_data2});
      end
   endtask

   task automatic test_basic();
      reset_dut();
      run_frame(0, -1);
      n_checks++;
      if (first_valid !== 3) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 3", first_valid); end
      n_checks++;
      if (n_got !== 8) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 8", n_got); end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i) || got_cycle[i] !== 3 + i || got_last[i] !== (i == 7)) begin
            n_fail++;
            $display("[TB] FAIL basic_word%0d: got data %h cycle %0d last %b expected %h %0d %b",
                     i, got_data[i], got_cycle[i], got_last[i], 16'(i), 3 + i, (i == 7));
         end
      end
      n_checks++;
      if (done_cycle !== 11 || n_done !== 1) begin
         n_fail++;
         $display("[TB] FAIL basic_done: got cycle %0d pulses %0d expected 11 1", done_cycle, n_done);
      end
      n_checks++;
      if (busy_drop !== 0 || end_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_busy: got drops %0d end %b expected 0 0", busy_drop, end_busy);
      end
      n_checks++;
      if (addr_read !== 3'd0) begin n_fail++; $display("[TB] FAIL basic_addr_rewind: got %0d expected 0", addr_read); end
   endtask

   task automatic test_backpressure();
      reset_dut();
      run_frame(1, -1);
      n_checks++;
      if (n_got !== 8 || done_cycle < 0) begin
         n_fail++;
         $display("[TB] FAIL bp_count: got %0d words done %0d expected 8 words and done", n_got, done_cycle);
      end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i) || got_last[i] !== (i == 7)) begin
            n_fail++;
            $display("[TB] FAIL bp_word%0d: got %h last %b expected %h %b", i, got_data[i], got_last[i], 16'(i), (i == 7));
         end
      end
      n_checks++;
      if (stable_err !== 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", stable_err); end
   endtask

   task automatic test_stall();
      reset_dut();
      run_frame(2, -1);
      n_checks++;
      if (stall_addr !== 3'd2) begin n_fail++; $display("[TB] FAIL stall_issue: got addr %0d expected 2", stall_addr); end
      n_checks++;
      if (n_got !== 8 || got_cycle[0] !== 14 || got_cycle[7] !== 21) begin
         n_fail++;
         $display("[TB] FAIL stall_resume: got %0d words first %0d last %0d expected 8 14 21",
                  n_got, got_cycle[0], got_cycle[7]);
      end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i)) begin
            n_fail++;
            $display("[TB] FAIL stall_word%0d: got %h expected %h", i, got_data[i], 16'(i));
         end
      end
      n_checks++;
      if (stable_err !== 0) begin n_fail++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", stable_err); end
   endtask

   task automatic test_restart_ignored();
      reset_dut();
      run_frame(0, 5);
      n_checks++;
      if (n_got !== 8 || n_done !== 1 || done_cycle !== 11 || busy_drop !== 0) begin
         n_fail++;
         $display("[TB] FAIL restart_ignored: got words %0d done %0d at %0d drops %0d expected 8 1 11 0",
                  n_got, n_done, done_cycle, busy_drop);
      end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i)) begin
            n_fail++;
            $display("[TB] FAIL restart_word%0d: got %h expected %h", i, got_data[i], 16'(i));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int accepted;
      reset_dut();
      accepted = 0;
      for (int k = 0; k < 20 && accepted < 4; k++) begin
         @(negedge clk);
         start = (k == 0);
         m_ready = 1'b1;
         #1;
         if (m_valid && m_ready) accepted++;
      end
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (accepted !== 4 || {m_valid, busy, done, m_last, write_enable, addr_read, addr_write, m_data, data_in} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid: got accepted %0d outputs %h expected 4 0", accepted,
                  {m_valid, busy, done, m_last, write_enable, addr_read, addr_write, m_data, data_in});
      end
      @(negedge clk);
      rst = 1'b0;
      do_preload();
      run_frame(0, -1);
      n_checks++;
      if (n_got !== 8 || first_valid !== 3) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_restart: got %0d words first %0d expected 8 3", n_got, first_valid);
      end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i)) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_word%0d: got %h expected %h", i, got_data[i], 16'(i));
         end
      end
   endtask

   task automatic test_clear();
      logic [15:0] exp_we_mask;
      int          exp_we_count;
      logic [15:0] exp_second [8];
`ifdef BRAM_STREAM_READER_CLEAR_EN
      exp_we_mask = 16'b0000_0001_1111_1110;
      exp_we_count = 8;
      for (int i = 0; i < 8; i++) exp_second[i] = CLR;
`else
      exp_we_mask = 16'h0000;
      exp_we_count = 0;
      for (int i = 0; i < 8; i++) exp_second[i] = 16'(i);
`endif
      reset_dut();
      run_frame(0, -1);
      n_checks++;
      if (we_count !== exp_we_count || we_mask !== exp_we_mask) begin
         n_fail++;
         $display("[TB] FAIL clear_we: got count %0d mask %b expected %0d %b", we_count, we_mask, exp_we_count, exp_we_mask);
      end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== 16'(i)) begin
            n_fail++;
            $display("[TB] FAIL clear_first%0d: got %h expected %h", i, got_data[i], 16'(i));
         end
      end
      run_frame(0, -1);
      n_checks++;
      if (n_got !== 8) begin n_fail++; $display("[TB] FAIL clear_second_count: got %0d expected 8", n_got); end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_checks++;
         if (got_data[i] !== exp_second[i]) begin
            n_fail++;
            $display("[TB] FAIL clear_second%0d: got %h expected %h", i, got_data[i], exp_second[i]);
         end
      end
   endtask

   task automatic test_depth2();
      logic [15:0] d2_data [4];
      logic        d2_last [4];
      int          d2_n, d2_done;
      logic        d2_end_busy;
      reset_dut();
      d2_n = 0; d2_done = -1; d2_end_busy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start2 = (k == 0);
         m_ready2 = 1'b1;
         #1;
         if (m_valid2 && m_ready2 && d2_n < 4) begin
            d2_data[d2_n] = m_data2; d2_last[d2_n] = m_last2; d2_n++;
         end
         if (done2 && d2_done < 0) d2_done = k;
         if (d2_done >= 0 && k == d2_done + 1) begin
            d2_end_busy = busy2;
            break;
         end
      end
      start2 = 1'b0;
      n_checks++;
      if (d2_n !== 2 || d2_done !== 5 || d2_end_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL depth2_frame: got words %0d done %0d busy %b expected 2 5 0", d2_n, d2_done, d2_end_busy);
      end
      n_checks++;
      if (d2_n == 2 && (d2_data[0] !== 16'd0 || d2_data[1] !== 16'd1 || d2_last[0] !== 1'b0 || d2_last[1] !== 1'b1)) begin
         n_fail++;
         $display("[TB] FAIL depth2_words: got %h/%b %h/%b expected 0000/0 0001/1",
                  d2_data[0], d2_last[0], d2_data[1], d2_last[1]);
      end
   endtask

   initial begin
      $display("[TB] bram_stream_reader directed tests starting");
      test_reset();
      test_basic();
      test_backpressure();
      test_stall();
      test_restart_ignored();
      test_reset_mid_frame();
      test_clear();
      test_depth2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
